// File: rtl/trolley_mem_pkg.sv
// trolley_mem_pkg: shared widths, constants and FSM states for the memory copy master
package trolley_mem_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 13;

    localparam logic [DEF_DATA_W/8-1:0] BE_ALL = '1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        FINISH
    } state_t;

endpackage

// File: rtl/trolley_system_mem_copy_master.sv
// trolley_system_mem_copy_master: Avalon-MM master copying len words from src to dst, one transaction at a time
module trolley_system_mem_copy_master
    import trolley_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [LEN_W-1:0]    words_done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   src, dst, src_nxt, dst_nxt, address_nxt;
    logic [LEN_W-1:0]    len_q, len_nxt, words_done_nxt, count_inc;
    logic                abort_pend, abort_nxt;
    logic                busy_nxt, done_nxt, aborted_nxt, read_nxt, write_nxt;
    logic [DATA_W-1:0]   writedata_nxt;

    assign avm_byteenable = '1;
    assign count_inc      = words_done + 1'b1;

    // Next-state and next-output logic; avm_writedata doubles as the word buffer
    always_comb begin
        state_nxt      = state;
        src_nxt        = src;
        dst_nxt        = dst;
        len_nxt        = len_q;
        abort_nxt      = abort_pend | (abort && state != IDLE);
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        aborted_nxt    = aborted;
        words_done_nxt = words_done;
        read_nxt       = avm_read;
        write_nxt      = avm_write;
        address_nxt    = avm_address;
        writedata_nxt  = avm_writedata;
        case (state)
            IDLE: begin
                if (start) begin
                    src_nxt        = src_addr;
                    dst_nxt        = dst_addr;
                    len_nxt        = len;
                    words_done_nxt = '0;
                    aborted_nxt    = 1'b0;
                    abort_nxt      = 1'b0;
                    busy_nxt       = 1'b1;
                    if (len == '0) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt   = RD_REQ;
                        read_nxt    = 1'b1;
                        address_nxt = src_addr;
                    end
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    read_nxt = 1'b0;
                    if (avm_readdatavalid) begin
                        state_nxt     = WR_REQ;
                        write_nxt     = 1'b1;
                        address_nxt   = dst;
                        writedata_nxt = avm_readdata;
                    end else begin
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    state_nxt     = WR_REQ;
                    write_nxt     = 1'b1;
                    address_nxt   = dst;
                    writedata_nxt = avm_readdata;
                end
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    write_nxt      = 1'b0;
                    words_done_nxt = count_inc;
                    src_nxt        = src + 1'b1;
                    dst_nxt        = dst + 1'b1;
                    if (count_inc == len_q || abort_nxt) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt   = RD_REQ;
                        read_nxt    = 1'b1;
                        address_nxt = src + 1'b1;
                    end
                end
            end
            FINISH: begin
                state_nxt   = IDLE;
                done_nxt    = 1'b1;
                busy_nxt    = 1'b0;
                abort_nxt   = 1'b0;
                aborted_nxt = words_done < len_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset returns everything to idle immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            len_q         <= '0;
            abort_pend    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            words_done    <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            state         <= state_nxt;
            src           <= src_nxt;
            dst           <= dst_nxt;
            len_q         <= len_nxt;
            abort_pend    <= abort_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            aborted       <= aborted_nxt;
            words_done    <= words_done_nxt;
            avm_read      <= read_nxt;
            avm_write     <= write_nxt;
            avm_address   <= address_nxt;
            avm_writedata <= writedata_nxt;
        end
    end

endmodule

// File: tb/tb_trolley_system_mem_copy_master.sv
// tb_trolley_system_mem_copy_master: scoreboard bench with an Avalon memory model for the copy master
`timescale 1ns/1ps
module tb_trolley_system_mem_copy_master;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int wd;
        bit ab;
        int lat;
    } done_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] src_addr = '0;
    logic [11:0] dst_addr = '0;
    logic [12:0] len = '0;
    logic        busy, done, aborted;
    logic [12:0] words_done;
    logic [11:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        wait_req = 1'b0;
    logic [31:0] rdata = '0;
    logic        rdv = 1'b0;

    logic [31:0] mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [11:0] rd_q [$];
    wr_t         wr_q [$];
    done_t       done_q [$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int rd_acc_cnt = 0;
    bit stall_en = 0;
    bit force_wait = 0;
    int pend_cnt = 0;
    logic [31:0] pend_data = '0;

    bit          prev_stall = 0;
    logic        prev_rd, prev_wr;
    logic [11:0] prev_addr;
    logic [31:0] prev_wdata;

    trolley_system_mem_copy_master dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .abort             (abort),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .len               (len),
        .busy              (busy),
        .done              (done),
        .aborted           (aborted),
        .words_done        (words_done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (wait_req),
        .avm_readdata      (rdata),
        .avm_readdatavalid (rdv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string got, input string want);
        compared++;
        mismatched++;
        $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    // Slave model: waitrequest, variable read latency, memory writes on acceptance
    always @(negedge clk) begin
        if (!reset_n) begin
            pend_cnt = 0;
            rdv = 1'b0;
            wait_req = 1'b0;
        end else begin
            wait_req = force_wait || (stall_en && $urandom_range(0, 1) == 1);
            rdv = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    rdv = 1'b1;
                    rdata = pend_data;
                end
            end
            if (avm_read && !wait_req) begin
                int d;
                d = stall_en ? int'($urandom_range(0, 3)) : 1;
                if (d == 0) begin
                    rdv = 1'b1;
                    rdata = mem[avm_address];
                end else begin
                    pend_cnt = d;
                    pend_data = mem[avm_address];
                end
            end
            if (avm_write && !wait_req) mem[avm_address] = avm_writedata;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transaction or done
    always @(negedge clk) begin
        #1;
        if (!reset_n) begin
            prev_stall = 0;
        end else begin
            if (avm_read && avm_write) fail("rd_wr_overlap", "read and write", "exclusive");
            if (prev_stall) begin
                chk("hold_read", avm_read, prev_rd);
                chk("hold_write", avm_write, prev_wr);
                chk("hold_addr", avm_address, prev_addr);
                if (prev_wr) chk("hold_wdata", avm_writedata, prev_wdata);
            end
            prev_stall = (avm_read || avm_write) && wait_req;
            prev_rd = avm_read;
            prev_wr = avm_write;
            prev_addr = avm_address;
            prev_wdata = avm_writedata;
            if (avm_read && !wait_req) begin
                if (rd_q.size() == 0) fail("unexpected_read", "read", "no read");
                else chk("rd_addr", avm_address, rd_q.pop_front());
                rd_acc_cnt++;
            end
            if (avm_write && !wait_req) begin
                if (wr_q.size() == 0) fail("unexpected_write", "write", "no write");
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", avm_address, w.a);
                    chk("wr_data", avm_writedata, w.d);
                end
            end
            if (done) begin
                if (done_q.size() == 0) fail("unexpected_done", "done", "no done");
                else begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("done_words", words_done, e.wd);
                    chk("done_aborted", aborted, e.ab);
                    chk("done_busy", busy, 0);
                    if (e.lat >= 0) chk("done_latency", cyc - start_cyc, e.lat);
                end
                done_cnt++;
            end
        end
    end

    task automatic preload();
        for (int i = 0; i < 4096; i++) begin
            mem[i] = i ^ 32'hA5A5_0000;
            ref_mem[i] = i ^ 32'hA5A5_0000;
        end
    endtask

    task automatic do_copy(input logic [11:0] s, input logic [11:0] d, input logic [12:0] l,
                           input int nwords, input bit ab, input int lat, input bit with_abort);
        logic [11:0] sa, da;
        for (int i = 0; i < nwords; i++) begin
            sa = 12'(s + i);
            da = 12'(d + i);
            rd_q.push_back(sa);
            wr_q.push_back('{da, ref_mem[sa]});
            ref_mem[da] = ref_mem[sa];
        end
        done_q.push_back('{nwords, ab, lat});
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len = l;
        start = 1'b1;
        abort = with_abort;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int maxc, input string name);
        for (int i = 0; i < maxc && done_cnt == n0; i++) @(negedge clk);
        if (done_cnt == n0) fail({name, "_timeout"}, "no done", "done");
        @(negedge clk);
    endtask

    initial begin
        int n0;
        int base;
        bit found;
        preload();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_words", words_done, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_wdata", avm_writedata, 0);
        chk("byteenable", avm_byteenable, 4'hF);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // 1: basic copy, plus a start pulse while busy that must be ignored
        n0 = done_cnt;
        do_copy(12'd0, 12'd100, 13'd4, 4, 0, 14, 0);
        repeat (3) @(negedge clk);
        src_addr = 12'd7;
        dst_addr = 12'd500;
        len = 13'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n0, 100, "t1");
        chk("t1_mem100", mem[100], 32'hA5A5_0000);
        chk("t1_mem101", mem[101], 32'hA5A5_0001);
        chk("t1_mem102", mem[102], 32'hA5A5_0002);
        chk("t1_mem103", mem[103], 32'hA5A5_0003);
        chk("t1_mem500", mem[500], 32'hA5A5_01F4);

        // 2: random stalls and read latency
        preload();
        stall_en = 1;
        n0 = done_cnt;
        do_copy(12'd200, 12'd1000, 13'd64, 64, 0, -1, 0);
        wait_done(n0, 3000, "t2");
        stall_en = 0;
        chk("t2_mem1063", mem[1063], 32'hA5A5_0107);

        // 3: zero length
        n0 = done_cnt;
        do_copy(12'd5, 12'd6, 13'd0, 0, 0, 2, 0);
        wait_done(n0, 20, "t3");

        // 4: address wrap with overlapping forward copy
        preload();
        n0 = done_cnt;
        do_copy(12'd4094, 12'd4095, 13'd3, 3, 0, 11, 0);
        wait_done(n0, 100, "t4");
        chk("t4_mem4095", mem[4095], 32'hA5A5_0FFE);
        chk("t4_mem0", mem[0], 32'hA5A5_0FFE);
        chk("t4_mem1", mem[1], 32'hA5A5_0FFE);

        // 5: abort while the write of word 5 is stalled
        preload();
        n0 = done_cnt;
        do_copy(12'd300, 12'd2000, 13'd20, 6, 1, -1, 0);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (avm_write && avm_address == 12'd2005) found = 1;
        end
        if (!found) fail("t5_find_write", "no write to 2005", "write to 2005");
        force_wait = 1;
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(posedge clk);
        #1 force_wait = 0;
        wait_done(n0, 100, "t5");
        chk("t5_mem2006", mem[2006], 32'hA5A5_07D6);

        // 6: reset during RD_WAIT, then a normal copy
        preload();
        base = rd_acc_cnt;
        do_copy(12'd400, 12'd1500, 13'd8, 8, 0, -1, 0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #2;
            if (rd_acc_cnt >= base + 3) found = 1;
        end
        if (!found) fail("t6_find_read", "fewer than 3 reads", "3 reads");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_words", words_done, 0);
        chk("t6_read", avm_read, 0);
        chk("t6_write", avm_write, 0);
        chk("t6_addr", avm_address, 0);
        chk("t6_wdata", avm_writedata, 0);
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        @(posedge clk);
        #3 reset_n = 1'b1;
        preload();
        n0 = done_cnt;
        do_copy(12'd50, 12'd3000, 13'd3, 3, 0, 11, 0);
        wait_done(n0, 100, "t6b");

        // 7: abort in idle is ignored, and start+abort together starts normally
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n0 = done_cnt;
        do_copy(12'd10, 12'd20, 13'd2, 2, 0, 8, 1);
        wait_done(n0, 100, "t7");

        repeat (3) @(negedge clk);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
